// File: rtl/wallace_reduce_pipe_pkg.sv
// Shared constants for the 16x16 Wallace-tree reduction front end:
// operand/product widths, rows per reduction level, and the pipeline cut.
package wallace_reduce_pipe_pkg;
  localparam int WIDTH  = 16;
  localparam int PROD_W = 2 * WIDTH;

  // Row count after each 3:2 level: 16 -> 11 -> 8 -> 6 | 6 -> 4 -> 3 -> 2
  localparam int ROWS_L0 = 16;
  localparam int ROWS_L1 = 11;
  localparam int ROWS_L2 = 8;
  localparam int ROWS_L3 = 6;
  localparam int ROWS_L4 = 4;
  localparam int ROWS_L5 = 3;
  localparam int ROWS_L6 = 2;

  // Stage-1 register sits after this level
  localparam int CUT_LEVEL = 3;
  localparam int CUT_ROWS  = ROWS_L3;

  typedef logic [PROD_W-1:0] row_t;
endpackage

// File: rtl/wallace_reduce_pipe_csa_row.sv
// One PROD_W-bit 3:2 carry-save compressor row; the carry row is returned
// already shifted to its weight, dropping the carry out of the top bit.
module csa_row
  import wallace_reduce_pipe_pkg::*;
(
  input  logic [PROD_W-1:0] x,
  input  logic [PROD_W-1:0] y,
  input  logic [PROD_W-1:0] z,
  output logic [PROD_W-1:0] s,
  output logic [PROD_W-1:0] c
);
  assign s = x ^ y ^ z;
  assign c = {(x[PROD_W-2:0] & y[PROD_W-2:0]) |
              (x[PROD_W-2:0] & z[PROD_W-2:0]) |
              (y[PROD_W-2:0] & z[PROD_W-2:0]), 1'b0};
endmodule

// File: rtl/wallace_reduce_pipe.sv
// 16x16 unsigned partial-product generation and Wallace reduction to two
// carry-save rows, split over a two-stage valid/ready elastic pipeline.
module wallace_reduce_pipe
  import wallace_reduce_pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] sum_vec,
  output logic [PROD_W-1:0] carry_vec
);
  row_t l0 [ROWS_L0];
  row_t l1 [ROWS_L1];
  row_t l2 [ROWS_L2];
  row_t l3 [ROWS_L3];
  row_t s1_rows_reg [CUT_ROWS];
  row_t l4 [ROWS_L4];
  row_t l5 [ROWS_L5];
  row_t l6 [ROWS_L6];

  logic s1_valid_reg;
  logic s2_valid_reg;
  row_t sum_reg;
  row_t carry_reg;
  logic s1_load;
  logic s2_load;

  genvar gi;

  // Row gi holds a & b[gi] at weight gi
  for (gi = 0; gi < ROWS_L0; gi++) begin : g_pp
    assign l0[gi] = row_t'(a & {WIDTH{b[gi]}}) << gi;
  end

  for (gi = 0; gi < 5; gi++) begin : g_l1
    csa_row u_csa (.x(l0[3*gi]), .y(l0[3*gi+1]), .z(l0[3*gi+2]),
                   .s(l1[2*gi]), .c(l1[2*gi+1]));
  end
  assign l1[10] = l0[15];

  for (gi = 0; gi < 3; gi++) begin : g_l2
    csa_row u_csa (.x(l1[3*gi]), .y(l1[3*gi+1]), .z(l1[3*gi+2]),
                   .s(l2[2*gi]), .c(l2[2*gi+1]));
  end
  assign l2[6] = l1[9];
  assign l2[7] = l1[10];

  for (gi = 0; gi < 2; gi++) begin : g_l3
    csa_row u_csa (.x(l2[3*gi]), .y(l2[3*gi+1]), .z(l2[3*gi+2]),
                   .s(l3[2*gi]), .c(l3[2*gi+1]));
  end
  assign l3[4] = l2[6];
  assign l3[5] = l2[7];

  // Stage 2 works from the registered six rows
  for (gi = 0; gi < 2; gi++) begin : g_l4
    csa_row u_csa (.x(s1_rows_reg[3*gi]), .y(s1_rows_reg[3*gi+1]),
                   .z(s1_rows_reg[3*gi+2]), .s(l4[2*gi]), .c(l4[2*gi+1]));
  end

  csa_row u_csa_l5 (.x(l4[0]), .y(l4[1]), .z(l4[2]), .s(l5[0]), .c(l5[1]));
  assign l5[2] = l4[3];

  csa_row u_csa_l6 (.x(l5[0]), .y(l5[1]), .z(l5[2]), .s(l6[0]), .c(l6[1]));

  assign s2_load  = !s2_valid_reg || out_ready;
  assign s1_load  = !s1_valid_reg || s2_load;
  assign in_ready = s1_load;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
      sum_reg      <= '0;
      carry_reg    <= '0;
      for (int i = 0; i < CUT_ROWS; i++) s1_rows_reg[i] <= '0;
    end else begin
      if (s1_load) begin
        s1_valid_reg <= in_valid;
        for (int i = 0; i < CUT_ROWS; i++) s1_rows_reg[i] <= l3[i];
      end
      if (s2_load) begin
        s2_valid_reg <= s1_valid_reg;
        sum_reg      <= l6[0];
        carry_reg    <= l6[1];
      end
    end
  end

  assign out_valid = s2_valid_reg;
  assign sum_vec   = sum_reg;
  assign carry_vec = carry_reg;
endmodule

// File: tb/tb_wallace_reduce_pipe.sv
// Self-checking bench for wallace_reduce_pipe: directed scenarios plus a
// randomized soak against a queue of a*b products.
module tb_wallace_reduce_pipe;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum_vec;
  logic [31:0] carry_vec;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wallace_reduce_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .sum_vec(sum_vec), .carry_vec(carry_vec)
  );

  function automatic logic [31:0] prod(input logic [15:0] x, input logic [15:0] y);
    return 32'(x) * 32'(y);
  endfunction

  function automatic logic [31:0] total();
    return sum_vec + carry_vec;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    step(); step();
    rst_n = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++;
    if (sum_vec !== 32'h0 || carry_vec !== 32'h0) begin
      failures++; $display("FAIL reset_vectors sum=%h carry=%h want=0/0", sum_vec, carry_vec);
    end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    $display("test_reset done");
  endtask

  task automatic test_all_ones();
    a = 16'hFFFF; b = 16'hFFFF; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL ones_early_valid got=%b want=0", out_valid); end
    step();
    checks++;
    if (out_valid !== 1'b1 || total() !== 32'hFFFE0001) begin
      failures++; $display("FAIL ones_result valid=%b sum=%h want=1/fffe0001", out_valid, total());
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL ones_drained got=%b want=0", out_valid); end
    $display("test_all_ones product=%h", 32'hFFFE0001);
  endtask

  task automatic test_back_to_back();
    logic [15:0] va [3] = '{16'h0001, 16'h1234, 16'h8000};
    logic [15:0] vb [3] = '{16'h0001, 16'h5678, 16'h0002};
    logic [31:0] ve [3] = '{32'h00000001, 32'h06260060, 32'h00010000};
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k < 3) begin a = va[k]; b = vb[k]; in_valid = 1'b1; end
      else in_valid = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready k=%0d got=%b want=1", k, in_ready); end
      step();
      if (k >= 1 && k <= 3) begin
        checks++;
        if (out_valid !== 1'b1 || total() !== ve[k-1]) begin
          failures++; $display("FAIL b2b_out k=%0d valid=%b sum=%h want=1/%h", k, out_valid, total(), ve[k-1]);
        end
        $display("b2b beat %0d sum=%h", k-1, total());
      end
    end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_tail_valid got=%b want=0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [31:0] hs, hc;
    out_ready = 1'b0;
    a = 16'h00FF; b = 16'h0101; in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready0 got=%b want=1", in_ready); end
    step();
    a = 16'hBEEF; b = 16'h1001;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready1 got=%b want=1", in_ready); end
    step();
    a = 16'h7777; b = 16'h3333;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready2 got=%b want=0", in_ready); end
    checks++;
    if (out_valid !== 1'b1 || total() !== prod(16'h00FF, 16'h0101)) begin
      failures++; $display("FAIL bp_first valid=%b sum=%h want=1/%h", out_valid, total(), prod(16'h00FF, 16'h0101));
    end
    hs = sum_vec; hc = carry_vec;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || sum_vec !== hs || carry_vec !== hc || in_ready !== 1'b0) begin
        failures++; $display("FAIL bp_frozen k=%0d valid=%b sum=%h carry=%h ready=%b want=1/%h/%h/0",
                             k, out_valid, sum_vec, carry_vec, in_ready, hs, hc);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || total() !== prod(16'hBEEF, 16'h1001)) begin
      failures++; $display("FAIL bp_second valid=%b sum=%h want=1/%h", out_valid, total(), prod(16'hBEEF, 16'h1001));
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_no_dup got=%b want=0", out_valid); end
    $display("test_backpressure done");
  endtask

  task automatic test_zero();
    out_ready = 1'b1;
    a = 16'h0000; b = 16'hABCD; in_valid = 1'b1;
    step();
    a = 16'hABCD; b = 16'h0000;
    step();
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || total() !== 32'h0) begin
      failures++; $display("FAIL zero_a valid=%b sum=%h want=1/0", out_valid, total());
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || total() !== 32'h0) begin
      failures++; $display("FAIL zero_b valid=%b sum=%h want=1/0", out_valid, total());
    end
    step();
    $display("test_zero done");
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b1;
    a = 16'h1111; b = 16'h2222; in_valid = 1'b1;
    step();
    a = 16'h3333; b = 16'h4444;
    step();
    in_valid = 1'b0; rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || sum_vec !== 32'h0 || carry_vec !== 32'h0) begin
      failures++; $display("FAIL midrst_clear valid=%b sum=%h carry=%h want=0/0/0", out_valid, sum_vec, carry_vec);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        failures++; $display("FAIL midrst_stale k=%0d valid=%b ready=%b want=0/1", k, out_valid, in_ready);
      end
    end
    $display("test_reset_midflight done");
  endtask

  task automatic test_random();
    logic [31:0] sb [$];
    logic [31:0] exp_v;
    logic [31:0] hs, hc;
    logic        stalled = 1'b0;
    int          accepted = 0;
    int          emitted = 0;
    int          cyc = 0;
    while (accepted < 10000 && cyc < 60000) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      a = 16'($urandom);
      b = 16'($urandom);
      if ($urandom_range(0, 15) == 0) a = 16'hFFFF;
      if ($urandom_range(0, 15) == 0) b = 16'h0000;
      #1;
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || sum_vec !== hs || carry_vec !== hc) begin
          failures++; $display("FAIL rnd_hold cyc=%0d valid=%b sum=%h carry=%h want=1/%h/%h",
                               cyc, out_valid, sum_vec, carry_vec, hs, hc);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL rnd_spurious cyc=%0d sum=%h want=no beat", cyc, total());
        end else begin
          exp_v = sb.pop_front();
          if (total() !== exp_v) begin
            failures++; $display("FAIL rnd_beat cyc=%0d got=%h want=%h", cyc, total(), exp_v);
          end
        end
        emitted++;
      end
      stalled = out_valid && !out_ready;
      hs = sum_vec; hc = carry_vec;
      if (in_valid && in_ready) begin
        sb.push_back(prod(a, b));
        accepted++;
      end
      step();
      cyc++;
    end
    checks++;
    if (accepted < 10000) begin failures++; $display("FAIL rnd_budget accepted=%0d want=10000", accepted); end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (out_valid) begin
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL rnd_drain_spurious sum=%h want=no beat", total());
        end else begin
          exp_v = sb.pop_front();
          if (total() !== exp_v) begin failures++; $display("FAIL rnd_drain got=%h want=%h", total(), exp_v); end
        end
        emitted++;
      end
      step();
    end
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL rnd_lost left=%0d want=0", sb.size()); end
    $display("test_random accepted=%0d emitted=%0d cycles=%0d", accepted, emitted, cyc);
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_back_to_back();
    test_backpressure();
    test_zero();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
